// File: rtl/ycr_mem_req_sched.sv
// Round-robin scheduler sharing one memory request port between N_REQ requesters,
// with an in-order ID FIFO that routes responses back to the issuing requester.
module ycr_mem_req_sched #(
    parameter int N_REQ  = 3,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int OUTSTD = 4,
    parameter int IDW    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_REQ-1:0]     m_req,
    input  logic [N_REQ-1:0]     m_cmd,
    input  logic [2*N_REQ-1:0]   m_width,
    input  logic [AW*N_REQ-1:0]  m_addr,
    input  logic [DW*N_REQ-1:0]  m_wdata,
    output logic [N_REQ-1:0]     m_req_ack,
    output logic [2*N_REQ-1:0]   m_resp,
    output logic [DW-1:0]        m_rdata,
    output logic                 s_req,
    output logic                 s_cmd,
    output logic [1:0]           s_width,
    output logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_wdata,
    input  logic                 s_req_ack,
    input  logic [1:0]           s_resp,
    input  logic [DW-1:0]        s_rdata,
    output logic [IDW:0]         gnt_id,
    output logic                 busy,
    output logic                 err_unexp
);

    localparam int unsigned      NR       = N_REQ;
    localparam int unsigned      PW       = $clog2(OUTSTD);
    localparam logic [PW:0]      CNT_FULL = (PW+1)'(OUTSTD);
    localparam logic [IDW-1:0]   LAST_ID  = IDW'(N_REQ - 1);

    logic [IDW-1:0] rr_ptr;
    logic           lock;
    logic [IDW-1:0] lock_id;
    logic [IDW-1:0] fifo [OUTSTD];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    cnt;

    logic           has_gnt;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           full;
    logic           hs;
    logic           pop;
    logic [IDW-1:0] head;

    // A stalled grant stays locked; otherwise scan from rr_ptr with wrap.
    always_comb begin
        has_gnt = 1'b0;
        win     = '0;
        cand    = '0;
        if (lock && m_req[lock_id]) begin
            has_gnt = 1'b1;
            win     = lock_id;
        end else begin
            for (int unsigned i = 0; i < NR; i++) begin
                cand = IDW'((32'(rr_ptr) + i) % NR);
                if (!has_gnt && m_req[cand]) begin
                    has_gnt = 1'b1;
                    win     = cand;
                end
            end
        end
    end

    assign full  = (cnt == CNT_FULL);
    assign s_req = has_gnt && !full;
    assign hs    = s_req && s_req_ack;
    assign head  = fifo[rd_ptr];
    assign pop   = (s_resp != 2'b00) && (cnt != '0);

    always_comb begin
        s_cmd     = 1'b0;
        s_width   = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_req_ack = '0;
        m_resp    = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (has_gnt && win == IDW'(i)) begin
                s_cmd        = m_cmd[i];
                s_width      = m_width[2*i +: 2];
                s_addr       = m_addr[AW*i +: AW];
                s_wdata      = m_wdata[DW*i +: DW];
                m_req_ack[i] = hs;
            end
            if (pop && head == IDW'(i)) begin
                m_resp[2*i +: 2] = s_resp;
            end
        end
    end

    assign m_rdata   = s_rdata;
    assign gnt_id    = has_gnt ? {1'b0, win} : '1;
    assign busy      = (cnt != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            lock      <= 1'b0;
            lock_id   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            err_unexp <= 1'b0;
            for (int unsigned i = 0; i < OUTSTD; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            // While full the arbiter is frozen: neither pointer nor lock moves.
            if (!full) begin
                if (hs) begin
                    lock   <= 1'b0;
                    rr_ptr <= (win == LAST_ID) ? '0 : win + IDW'(1);
                end else if (s_req) begin
                    lock    <= 1'b1;
                    lock_id <= win;
                end else begin
                    lock <= 1'b0;
                end
            end
            if (hs) begin
                fifo[wr_ptr] <= win;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (hs && !pop) begin
                cnt <= cnt + (PW+1)'(1);
            end else if (pop && !hs) begin
                cnt <= cnt - (PW+1)'(1);
            end
            if ((s_resp != 2'b00) && (cnt == '0)) begin
                err_unexp <= 1'b1;
            end
        end
    end

endmodule
